// File: rtl/link_spi_tx_scheduler_pkg.sv
// link_spi_pkg: shared types for the SPI link transmit scheduler
//   TCommandCode : command code carried to the SPI encoder (service protocol command set)
//   TLinkTxState : scheduler FSM states
//   TLinkReq     : latched request fields {addr, cmd, size}
//   rr_next      : round-robin successor of a channel index
package link_spi_pkg;

    typedef enum logic [3:0] {
        CMD_NOP    = 4'h0,
        CMD_READ   = 4'h1,
        CMD_WRITE  = 4'h2,
        CMD_STATUS = 4'h3,
        CMD_RESET  = 4'hF
    } TCommandCode;

    localparam int CMD_W      = $bits(TCommandCode);
    // widest supported packet size field; narrower SIZE_W values are zero-extended
    localparam int SIZE_MAX_W = 32;

    typedef enum logic [2:0] {IDLE, ARB, SEND, HOLD, ABORT} TLinkTxState;

    typedef struct packed {
        logic [7:0]            addr;
        TCommandCode           cmd;
        logic [SIZE_MAX_W-1:0] size;
    } TLinkReq;

    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/link_spi_rr_arbiter.sv
// link_spi_rr_arbiter: combinational round-robin channel picker
//   req_i     : per-channel request vector
//   ptr_i     : first channel to consider (one past the last grant)
//   gnt_oh_o  : one-hot grant
//   gnt_idx_o : grant index
//   gnt_vld_o : any channel granted
// Build option LINK_SPI_PRIO_EN: channel 0 wins whenever it requests; the
// remaining channels still rotate among themselves.
module link_spi_rr_arbiter #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]         req_i,
    input  logic [$clog2(N_CH)-1:0] ptr_i,
    output logic [N_CH-1:0]         gnt_oh_o,
    output logic [$clog2(N_CH)-1:0] gnt_idx_o,
    output logic                    gnt_vld_o
);

    localparam int IDX_W = $clog2(N_CH);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester after ptr_i wins.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        cand      = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr_i) + i) % N_CH);
            if (req_i[cand]) begin
                gnt_idx_o = cand;
                gnt_vld_o = 1'b1;
            end
        end
`ifdef LINK_SPI_PRIO_EN
        if (req_i[0]) begin
            gnt_idx_o = '0;
            gnt_vld_o = 1'b1;
        end
`else
`endif
        gnt_oh_o[gnt_idx_o] = gnt_vld_o;
    end

endmodule

// File: rtl/link_spi_tx_scheduler.sv
// link_spi_tx_scheduler: round-robin outbound packet scheduler and inbound stats for the SPI link
//   clk, rst                 : clock, asynchronous active-high reset
//   req/reqAddr/reqCmd/reqSize : per-channel level requests and packed request fields
//   ack                      : one-cycle per-channel completion pulse (ok or aborted)
//   outEnable/outAddr/outCmdCode/outDataSize : registered encoder control for the granted packet
//   wordPop, spiIsBusy       : encoder word consumption pulse, SPI transfer busy
//   inPacketStart/End/Err    : decoder status pulses
//   txAbort                  : one-cycle pulse when a stalled packet is aborted
//   grantCh                  : current / last granted channel
//   okCnt, errCnt            : saturating inbound packet counters
// Build option LINK_SPI_PRIO_EN gives channel 0 strict priority (see link_spi_rr_arbiter).
module link_spi_tx_scheduler
    import link_spi_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int SIZE_W  = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH*8-1:0]        reqAddr,
    input  logic [N_CH*CMD_W-1:0]    reqCmd,
    input  logic [N_CH*SIZE_W-1:0]   reqSize,
    output logic [N_CH-1:0]          ack,
    output logic                     outEnable,
    output logic [7:0]               outAddr,
    output logic [CMD_W-1:0]         outCmdCode,
    output logic [SIZE_W-1:0]        outDataSize,
    input  logic                     wordPop,
    input  logic                     spiIsBusy,
    input  logic                     inPacketStart,
    input  logic                     inPacketEnd,
    input  logic                     inPacketErr,
    output logic                     txAbort,
    output logic [$clog2(N_CH)-1:0]  grantCh,
    output logic [CNT_W-1:0]         okCnt,
    output logic [CNT_W-1:0]         errCnt
);

    localparam int IDX_W = $clog2(N_CH);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    TLinkTxState      state_q;
    TLinkReq          req_q;
    TLinkReq          arb_req;
    logic             out_en_q;
    logic             abort_q;
    logic [N_CH-1:0]  ack_q;
    logic [N_CH-1:0]  oh_q;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] ptr_q;
    logic [SIZE_W-1:0] wcnt_q;
    logic [SIZE_W-1:0] wcnt_d;
    logic [TMO_W-1:0] tmo_q;
    logic             size_hit;
    logic             done;
    logic [N_CH-1:0]  arb_oh;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_vld;
    logic [CNT_W-1:0] ok_q;
    logic [CNT_W-1:0] err_q;
    logic             err_seen_q;

    link_spi_rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx),
        .gnt_vld_o (arb_vld)
    );

    assign arb_req = '{
        addr: reqAddr[arb_idx*8 +: 8],
        cmd:  TCommandCode'(reqCmd[arb_idx*CMD_W +: CMD_W]),
        size: SIZE_MAX_W'(reqSize[arb_idx*SIZE_W +: SIZE_W])
    };

    // Pops arriving once the full size has been counted are dropped, so a
    // header-only packet leaves SEND after a single cycle.
    assign size_hit = SIZE_MAX_W'(wcnt_q) == req_q.size;
    assign wcnt_d   = (wordPop && !size_hit) ? wcnt_q + 1'b1 : wcnt_q;
    assign done     = SIZE_MAX_W'(wcnt_d) == req_q.size;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            req_q    <= '0;
            out_en_q <= 1'b0;
            abort_q  <= 1'b0;
            ack_q    <= '0;
            oh_q     <= '0;
            grant_q  <= '0;
            ptr_q    <= '0;
            wcnt_q   <= '0;
            tmo_q    <= '0;
        end else begin
            ack_q   <= '0;
            abort_q <= 1'b0;
            case (state_q)
                IDLE: if (|req) state_q <= ARB;
                ARB: begin
                    if (arb_vld) begin
                        req_q    <= arb_req;
                        oh_q     <= arb_oh;
                        grant_q  <= arb_idx;
                        ptr_q    <= IDX_W'(rr_next(int'(arb_idx), N_CH));
                        out_en_q <= 1'b1;
                        wcnt_q   <= '0;
                        tmo_q    <= '0;
                        state_q  <= SEND;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                SEND: begin
                    wcnt_q <= wcnt_d;
                    tmo_q  <= wordPop ? '0 : tmo_q + 1'b1;
                    if (done) begin
                        out_en_q <= 1'b0;
                        state_q  <= HOLD;
                    end else if (!wordPop && tmo_q == TMO_LAST) begin
                        out_en_q <= 1'b0;
                        abort_q  <= 1'b1;
                        ack_q    <= oh_q;
                        state_q  <= ABORT;
                    end
                end
                HOLD: begin
                    if (!spiIsBusy) begin
                        ack_q   <= oh_q;
                        state_q <= IDLE;
                    end
                end
                ABORT:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Errors are counted once per inbound packet; inPacketStart re-arms the flag,
    // and an error on the start cycle belongs to the new packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok_q       <= '0;
            err_q      <= '0;
            err_seen_q <= 1'b0;
        end else begin
            err_seen_q <= inPacketErr | (err_seen_q & ~inPacketStart);
            if (inPacketErr && (inPacketStart || !err_seen_q) && err_q != '1) err_q <= err_q + 1'b1;
            if (inPacketEnd && !inPacketErr && ok_q != '1) ok_q <= ok_q + 1'b1;
        end
    end

    assign ack         = ack_q;
    assign outEnable   = out_en_q;
    assign outAddr     = req_q.addr;
    assign outCmdCode  = req_q.cmd;
    assign outDataSize = SIZE_W'(req_q.size);
    assign txAbort     = abort_q;
    assign grantCh     = grant_q;
    assign okCnt       = ok_q;
    assign errCnt      = err_q;

endmodule

// File: tb/tb_link_spi_tx_scheduler.sv
// tb_link_spi_tx_scheduler: directed self-checking bench for link_spi_tx_scheduler
module tb_link_spi_tx_scheduler;
    import link_spi_pkg::*;

    localparam int N_CH = 4, SIZE_W = 16, CNT_W = 2, TIMEOUT = 16;

    logic        clk = 1'b0, rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] reqAddr = '0;
    logic [15:0] reqCmd = '0;
    logic [63:0] reqSize = '0;
    logic        wordPop = 1'b0, spiIsBusy = 1'b0;
    logic        inPacketStart = 1'b0, inPacketEnd = 1'b0, inPacketErr = 1'b0;
    logic [3:0]  ack;
    logic        outEnable, txAbort;
    logic [7:0]  outAddr;
    logic [3:0]  outCmdCode;
    logic [15:0] outDataSize;
    logic [1:0]  grantCh, okCnt, errCnt;

    int checks = 0, errors = 0;

    typedef struct {
        logic       st, en, er;
        logic [1:0] ok, err;
    } stat_vec_t;
    stat_vec_t tbl [12];

    link_spi_tx_scheduler #(.N_CH(N_CH), .SIZE_W(SIZE_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .reqAddr(reqAddr), .reqCmd(reqCmd), .reqSize(reqSize),
        .ack(ack), .outEnable(outEnable), .outAddr(outAddr), .outCmdCode(outCmdCode),
        .outDataSize(outDataSize), .wordPop(wordPop), .spiIsBusy(spiIsBusy),
        .inPacketStart(inPacketStart), .inPacketEnd(inPacketEnd), .inPacketErr(inPacketErr),
        .txAbort(txAbort), .grantCh(grantCh), .okCnt(okCnt), .errCnt(errCnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_fields(input int ch, input logic [7:0] a, input TCommandCode c, input logic [15:0] s);
        reqAddr[ch*8 +: 8]  = a;
        reqCmd[ch*4 +: 4]   = c;
        reqSize[ch*16 +: 16] = s;
    endtask

    task automatic wait_en(input string nm);
        int n = 0;
        while (!outEnable && n < 20) begin
            step();
            n++;
        end
        chk(nm, 32'(outEnable), 32'd1);
    endtask

    task automatic wait_ack(input string nm, input logic [3:0] exp);
        int n = 0;
        while (ack == 4'b0 && n < 40) begin
            step();
            n++;
        end
        chk(nm, 32'(ack), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_g;
        int n;
        tbl[0]  = '{0, 1, 0, 2'd1, 2'd0};
        tbl[1]  = '{0, 1, 0, 2'd2, 2'd0};
        tbl[2]  = '{0, 1, 1, 2'd2, 2'd1};
        tbl[3]  = '{0, 1, 0, 2'd3, 2'd1};
        tbl[4]  = '{0, 1, 0, 2'd3, 2'd1};
        tbl[5]  = '{0, 1, 0, 2'd3, 2'd1};
        tbl[6]  = '{0, 0, 1, 2'd3, 2'd1};
        tbl[7]  = '{1, 0, 0, 2'd3, 2'd1};
        tbl[8]  = '{0, 0, 1, 2'd3, 2'd2};
        tbl[9]  = '{0, 0, 1, 2'd3, 2'd2};
        tbl[10] = '{1, 0, 1, 2'd3, 2'd3};
        tbl[11] = '{1, 0, 1, 2'd3, 2'd3};

        // reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_en", 32'(outEnable), 0);
        step();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_abort", 32'(txAbort), 0);
        chk("rst_grant", 32'(grantCh), 0);
        chk("rst_size", 32'(outDataSize), 0);
        chk("rst_ok", 32'(okCnt), 0);
        chk("rst_err", 32'(errCnt), 0);
        rst = 1'b0;

        // all four channels held, size 1 each
        for (int c = 0; c < 4; c++) set_fields(c, 8'(8'h10 + c), CMD_WRITE, 16'd1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
`ifdef LINK_SPI_PRIO_EN
            exp_g = 2'd0;
`else
            exp_g = 2'(k % 4);
`endif
            wait_en("rr_en");
            chk("rr_grant", 32'(grantCh), 32'(exp_g));
            chk("rr_addr", 32'(outAddr), 32'(8'h10 + exp_g));
            wordPop = 1'b1;
            step();
            wordPop = 1'b0;
            chk("rr_en_drop", 32'(outEnable), 0);
            wait_ack("rr_ack", 4'b0001 << exp_g);
        end
        req = '0;
        step();
        chk("rr_ack_pulse", 32'(ack), 0);

        // single request on ch2, size 3, two-cycle latency
        set_fields(2, 8'h15, CMD_READ, 16'd3);
        req = 4'b0100;
        step();
        chk("lat_en_c1", 32'(outEnable), 0);
        step();
        chk("lat_en_c2", 32'(outEnable), 1);
        chk("t1_grant", 32'(grantCh), 2);
        chk("t1_addr", 32'(outAddr), 32'h15);
        chk("t1_cmd", 32'(outCmdCode), 32'(CMD_READ));
        chk("t1_size", 32'(outDataSize), 3);
        wordPop = 1'b1;
        step();
        step();
        chk("t1_en_2pop", 32'(outEnable), 1);
        step();
        wordPop = 1'b0;
        chk("t1_en_3pop", 32'(outEnable), 0);
        chk("t1_ack_hold", 32'(ack), 0);
        step();
        chk("t1_ack", 32'(ack), 32'b0100);
        req = '0;
        step();
        chk("t1_ack_pulse", 32'(ack), 0);

        // header-only packet on ch1 while SPI is busy
        set_fields(1, 8'h41, CMD_STATUS, 16'd0);
        spiIsBusy = 1'b1;
        req = 4'b0010;
        step();
        chk("z_en_arb", 32'(outEnable), 0);
        step();
        chk("z_en_send", 32'(outEnable), 1);
        step();
        chk("z_en_one", 32'(outEnable), 0);
        repeat (3) step();
        chk("z_ack_busy", 32'(ack), 0);
        spiIsBusy = 1'b0;
        step();
        chk("z_ack", 32'(ack), 32'b0010);
        req = '0;
        step();

        // stall timeout on ch3: size 5, only 2 pops
        set_fields(3, 8'h3C, CMD_WRITE, 16'd5);
        req = 4'b1000;
        wait_en("to_en");
        chk("to_grant", 32'(grantCh), 3);
        wordPop = 1'b1;
        step();
        step();
        wordPop = 1'b0;
        n = 0;
        while (!txAbort && n < 40) begin
            step();
            n++;
        end
        chk("to_cycles", 32'(n), 16);
        chk("to_ack", 32'(ack), 32'b1000);
        chk("to_en", 32'(outEnable), 0);
        set_fields(0, 8'h01, CMD_READ, 16'd1);
        req = 4'b0101;
        step();
        chk("to_abort_pulse", 32'(txAbort), 0);
        chk("to_ack_pulse", 32'(ack), 0);
        wait_en("to_next_en");
        chk("to_next_grant", 32'(grantCh), 0);
        wordPop = 1'b1;
        step();
        wordPop = 1'b0;
        wait_ack("to_next_ack", 4'b0001);
        req = '0;
        step();

        // reset in the middle of SEND
        set_fields(2, 8'h22, CMD_WRITE, 16'd4);
        req = 4'b0100;
        wait_en("mr_en");
        wordPop = 1'b1;
        step();
        wordPop = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mr_en_async", 32'(outEnable), 0);
        chk("mr_ack", 32'(ack), 0);
        step();
        chk("mr_ack_rst", 32'(ack), 0);
        rst = 1'b0;
        set_fields(0, 8'h01, CMD_STATUS, 16'd1);
        req = 4'b1001;
        step();
        chk("mr_ack_after", 32'(ack), 0);
        step();
        chk("mr_en", 32'(outEnable), 1);
        chk("mr_grant", 32'(grantCh), 0);
        chk("mr_cmd", 32'(outCmdCode), 32'(CMD_STATUS));
        wordPop = 1'b1;
        step();
        wordPop = 1'b0;
        wait_ack("mr_next_ack", 4'b0001);
        req = '0;
        step();

        // inbound statistics table
        for (int i = 0; i < 12; i++) begin
            inPacketStart = tbl[i].st;
            inPacketEnd   = tbl[i].en;
            inPacketErr   = tbl[i].er;
            step();
            chk($sformatf("stat_ok[%0d]", i), 32'(okCnt), 32'(tbl[i].ok));
            chk($sformatf("stat_err[%0d]", i), 32'(errCnt), 32'(tbl[i].err));
        end
        inPacketStart = 1'b0;
        inPacketEnd   = 1'b0;
        inPacketErr   = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
